// File: rtl/uart_tx_ctrl_if.sv
// Byte-in handshake plus the frame/strobe outputs that feed the downstream PTS shift register.
interface uart_tx_ctrl_if #(
    parameter int unsigned FIFO_DEPTH = 4
) ();
    logic [7:0]                  tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [9:0]                  parallel_out;
    logic                        load_enable;
    logic                        shift_enable;
    logic                        tx_busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, parallel_out, load_enable, shift_enable, tx_busy, fifo_count
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, parallel_out, load_enable, shift_enable, tx_busy, fifo_count
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO plus start/8N/stop framing that strobes an external
// LSB-first PTS shift register once per bit period.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic           clk,
    input logic           n_rst,
    uart_tx_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, STOP} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic [BW-1:0] baud_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    parallel_q;
    logic          load_q;
    logic          shift_q;
    logic          busy_q;
    logic          ready_q;
    logic          push;
    logic          pop;
    logic [9:0]    head_frame;

    always_comb begin
        push       = bus.tx_valid && ready_q;
        pop        = (state_q == LOAD);
        head_frame = {1'b1, mem_q[rd_ptr_q], 1'b0};
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    // Strobes are registered, so each is set on the edge before the cycle it must be high in.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            parallel_q <= '1;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            count_q <= count_d;
            ready_q <= (count_d < DEPTH_C);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q    <= LOAD;
                        load_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        parallel_q <= head_frame;
                    end
                end
                LOAD: begin
                    state_q    <= SEND;
                    bit_cnt_q  <= '0;
                    baud_cnt_q <= '0;
                    shift_q    <= 1'b1;
                end
                SEND: begin
                    if (baud_cnt_q == '0) begin
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        baud_cnt_q <= BAUD_MAX;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - BW'(1);
                        shift_q    <= (baud_cnt_q == BW'(1));
                    end
                end
                STOP: begin
                    baud_cnt_q <= baud_cnt_q - BW'(1);
                    // Decide one cycle early so the next LOAD lands exactly 10*B+1 after the last.
                    if (baud_cnt_q == BW'(1)) begin
                        if (count_q != '0) begin
                            state_q    <= LOAD;
                            load_q     <= 1'b1;
                            parallel_q <= head_frame;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready     = ready_q;
    assign bus.parallel_out = parallel_q;
    assign bus.load_enable  = load_q;
    assign bus.shift_enable = shift_q;
    assign bus.tx_busy      = busy_q;
    assign bus.fifo_count   = count_q;
endmodule
